// File: rtl/cache_perf_reporter.sv
// cache_perf_reporter: saturating cache-event counters with an on-request UART snapshot dump.
// Frame: header, eight counters MSB first, then XOR of every preceding byte.
module cache_perf_reporter #(
  parameter int unsigned CNT_W = 32,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] ev_i,
  input  logic       clear_i,
  input  logic       dump_req,
  input  logic       tx_busy,
  output logic [7:0] data_o,
  output logic       done,
  output logic       busy_o
);

  localparam int unsigned NCNT   = 8;
  localparam int unsigned BPC    = CNT_W / 8;
  localparam int unsigned NBYTE  = NCNT * BPC;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned FLAT_W = NCNT * CNT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTE + 1);

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_LOAD, S_ACK, S_DRAIN} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [NCNT-1:0][CNT_W-1:0]  r_cnt;
  logic [NCNT-1:0][CNT_W-1:0]  r_snap;
  logic                        r_dump_q;
  logic                        r_req;
  logic                        r_pend;
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            w_idx_nxt;
  logic [7:0]                  r_csum;
  logic [7:0]                  w_csum_nxt;
  logic [7:0]                  w_byte;
  logic [7:0]                  w_data_nxt;
  logic                        w_done_nxt;
  logic                        w_busy_nxt;
  logic [FLAT_W-1:0]           w_flat;
  logic [31:0]                 w_sh;

  // Live saturating counters; clear beats a same-cycle event
  always_ff @(posedge clk or negedge rstn) begin : p_cnt
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NCNT; i++) begin
        if (ev_i[i] && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge detect, registered so the FSM sees it one cycle after the first high sample
  always_ff @(posedge clk or negedge rstn) begin : p_req
    if (!rstn) begin
      r_dump_q <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      r_dump_q <= dump_req;
      r_req    <= dump_req & ~r_dump_q;
    end
  end

  // State register plus registered outputs and frame datapath
  always_ff @(posedge clk or negedge rstn) begin : p_state
    if (!rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_csum  <= '0;
      r_pend  <= 1'b0;
      r_snap  <= '0;
      data_o  <= '0;
      done    <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_csum  <= w_csum_nxt;
      data_o  <= w_data_nxt;
      done    <= w_done_nxt;
      busy_o  <= w_busy_nxt;
      if (r_state == S_SNAP) begin
        r_snap <= r_cnt;
      end
      if (r_req && (r_state != S_IDLE)) begin
        r_pend <= 1'b1;
      end else if ((r_state == S_IDLE) && (w_state_nxt == S_SNAP)) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE:  if (r_req || r_pend) w_state_nxt = S_SNAP;
      S_SNAP: begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = '0;
      end
      S_LOAD:  w_state_nxt = S_ACK;
      S_ACK:   if (tx_busy) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte mux: counter 0 sits in the top of the flattened snapshot so byte order is MSB first
  always_comb begin : p_byte
    w_flat = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      w_flat[(NCNT-1-i)*CNT_W +: CNT_W] = r_snap[i];
    end
    w_sh   = (32'(NBYTE) - 32'(w_idx_nxt)) << 3;
    w_byte = HDR;
    if (w_idx_nxt == LAST_IDX) begin
      w_byte = r_csum;
    end else if (w_idx_nxt != '0) begin
      w_byte = 8'(w_flat >> w_sh);
    end
  end

  always_comb begin : p_out
    w_data_nxt = data_o;
    w_done_nxt = 1'b0;
    w_csum_nxt = r_csum;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_LOAD) begin
      w_data_nxt = w_byte;
      w_done_nxt = 1'b1;
      if (w_idx_nxt != LAST_IDX) begin
        w_csum_nxt = ((r_state == S_SNAP) ? 8'h00 : r_csum) ^ w_byte;
      end
    end
  end

endmodule

// File: tb/tb_cache_perf_reporter.sv
// Directed bench for cache_perf_reporter: frame contents, latency, saturation, clear, overlap, stall.
module tb_cache_perf_reporter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] ev_i;
  logic       clear_i;
  logic       dump_req;
  logic       tx_busy;
  logic [7:0] data_o;
  logic       done;
  logic       busy_o;

  logic       auto_uart;
  logic       uart_busy;
  logic       man_busy;

  int         total = 0;
  int         bad   = 0;
  int         ndone = 0;
  logic [7:0] rx_q[$];
  logic [31:0] exp_cnt[8];
  logic [7:0]  exp_b[34];

  assign tx_busy = auto_uart ? uart_busy : man_busy;

  cache_perf_reporter dut (
    .clk      (clk),
    .rstn     (rstn),
    .ev_i     (ev_i),
    .clear_i  (clear_i),
    .dump_req (dump_req),
    .tx_busy  (tx_busy),
    .data_o   (data_o),
    .done     (done),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Byte collector
  always @(negedge clk) begin
    if (rstn && done) begin
      rx_q.push_back(data_o);
      ndone <= ndone + 1;
    end
  end

  // Simple uart_tx stand-in: busy rises 2 cycles after done and lasts 4 cycles
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_uart && done) begin
        repeat (2) @(negedge clk);
        uart_busy = 1'b1;
        repeat (4) @(negedge clk);
        uart_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; ev_i = '0; clear_i = 1'b0; dump_req = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    repeat (8) step();
  endtask

  task automatic pulse_dump();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
  endtask

  // Reference frame from exp_cnt: header, counters MSB first, XOR checksum
  task automatic build_exp();
    logic [7:0] x;
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++)
        exp_b[1 + 4*i + b] = exp_cnt[i][31 - 8*b -: 8];
    x = 8'h00;
    for (int i = 0; i < 33; i++) x = x ^ exp_b[i];
    exp_b[33] = x;
  endtask

  task automatic wait_frames(input int target, input string name);
    int c;
    c = 0;
    while (!((ndone >= target) && !busy_o) && (c < 6000)) begin
      step();
      c++;
    end
    if (c >= 6000) begin
      total++; bad++;
      $display("FAIL %s timeout done_count=%0d required=%0d", name, ndone, target);
    end
  endtask

  task automatic test_reset();
    int base, nd0;
    total++;
    if (data_o !== 8'h00 || done !== 1'b0 || busy_o !== 1'b0)
      begin bad++; $display("FAIL reset_init got data=%h done=%b busy=%b exp 00/0/0", data_o, done, busy_o); end
    rstn = 1'b1; step();
    ev_i = 8'hFF; repeat (4) step(); ev_i = '0;
    pulse_dump();
    repeat (5) step();
    total++;
    if (busy_o !== 1'b1 || data_o !== 8'hA5)
      begin bad++; $display("FAIL reset_midframe got data=%h busy=%b exp A5/1", data_o, busy_o); end
    #3 rstn = 1'b0;
    #1;
    total++;
    if (data_o !== 8'h00 || done !== 1'b0 || busy_o !== 1'b0)
      begin bad++; $display("FAIL reset_async got data=%h done=%b busy=%b exp 00/0/0", data_o, done, busy_o); end
    repeat (2) step();
    rstn = 1'b1;
    repeat (8) step();
    base = rx_q.size(); nd0 = ndone;
    for (int i = 0; i < 8; i++) exp_cnt[i] = 32'h0;
    build_exp();
    pulse_dump();
    wait_frames(nd0 + 34, "reset_frame");
    total++;
    if (ndone - nd0 !== 34) begin bad++; $display("FAIL reset_count got=%0d exp=34", ndone - nd0); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+i] !== exp_b[i])
        begin bad++; $display("FAIL reset_byte%0d got=%h exp=%h", i, rx_q[base+i], exp_b[i]); end
    end
  endtask

  task automatic test_basic();
    int base, nd0;
    do_reset();
    ev_i = 8'h01; repeat (3) step();
    ev_i = 8'h02; step();
    ev_i = 8'h00;
    base = rx_q.size(); nd0 = ndone;
    for (int i = 0; i < 8; i++) exp_cnt[i] = 32'h0;
    exp_cnt[0] = 32'd3; exp_cnt[1] = 32'd1;
    build_exp();
    dump_req = 1'b1; step(); dump_req = 1'b0;   // edge k
    step();                                     // edge k+1
    total++;
    if (busy_o !== 1'b1 || done !== 1'b0)
      begin bad++; $display("FAIL latency_snap got busy=%b done=%b exp 1/0", busy_o, done); end
    step();                                     // edge k+2
    total++;
    if (done !== 1'b1 || data_o !== 8'hA5)
      begin bad++; $display("FAIL latency_first got done=%b data=%h exp 1/A5", done, data_o); end
    wait_frames(nd0 + 34, "basic_frame");
    total++;
    if (ndone - nd0 !== 34) begin bad++; $display("FAIL basic_count got=%0d exp=34", ndone - nd0); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy_o); end
    total++;
    if (rx_q[base+33] !== 8'hA7) begin bad++; $display("FAIL basic_csum got=%h exp=A7", rx_q[base+33]); end
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+i] !== exp_b[i])
        begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, rx_q[base+i], exp_b[i]); end
    end
  endtask

  task automatic test_saturation();
    int base, nd0;
    do_reset();
    force dut.r_cnt = {32'hFFFF_FFFE, 224'h0};
    step();
    release dut.r_cnt;
    ev_i = 8'h80; repeat (5) step(); ev_i = 8'h00;
    base = rx_q.size(); nd0 = ndone;
    for (int i = 0; i < 8; i++) exp_cnt[i] = 32'h0;
    exp_cnt[7] = 32'hFFFF_FFFF;
    build_exp();
    pulse_dump();
    wait_frames(nd0 + 34, "sat_frame");
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+i] !== exp_b[i])
        begin bad++; $display("FAIL sat_byte%0d got=%h exp=%h", i, rx_q[base+i], exp_b[i]); end
    end
  endtask

  task automatic test_clear();
    int base, nd0;
    do_reset();
    ev_i = 8'h04; repeat (2) step();
    clear_i = 1'b1; step(); clear_i = 1'b0;
    ev_i = 8'h08; repeat (4) step(); ev_i = 8'h00;
    base = rx_q.size(); nd0 = ndone;
    for (int i = 0; i < 8; i++) exp_cnt[i] = 32'h0;
    exp_cnt[3] = 32'd4;
    build_exp();
    pulse_dump();
    repeat (60) step();
    clear_i = 1'b1; step(); clear_i = 1'b0;
    wait_frames(nd0 + 34, "clear_frame");
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+i] !== exp_b[i])
        begin bad++; $display("FAIL clear_byte%0d got=%h exp=%h", i, rx_q[base+i], exp_b[i]); end
    end
    // the mid-dump clear must have zeroed the live counters
    base = rx_q.size(); nd0 = ndone;
    exp_cnt[3] = 32'h0;
    build_exp();
    pulse_dump();
    wait_frames(nd0 + 34, "clear_frame2");
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+i] !== exp_b[i])
        begin bad++; $display("FAIL clear2_byte%0d got=%h exp=%h", i, rx_q[base+i], exp_b[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int base, nd0;
    do_reset();
    ev_i = 8'h01; repeat (2) step(); ev_i = 8'h00;
    base = rx_q.size(); nd0 = ndone;
    pulse_dump();
    repeat (40) step();
    ev_i = 8'h20; repeat (3) step();
    ev_i = 8'h40;
    repeat (3) begin
      dump_req = 1'b1; step();
      dump_req = 1'b0; step();
    end
    repeat (4) step();
    ev_i = 8'h00;
    wait_frames(nd0 + 68, "b2b_frames");
    repeat (100) step();
    total++;
    if (ndone - nd0 !== 68 || busy_o !== 1'b0)
      begin bad++; $display("FAIL b2b_count got=%0d busy=%b exp 68/0", ndone - nd0, busy_o); end
    for (int i = 0; i < 8; i++) exp_cnt[i] = 32'h0;
    exp_cnt[0] = 32'd2;
    build_exp();
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+i] !== exp_b[i])
        begin bad++; $display("FAIL b2b_f1_byte%0d got=%h exp=%h", i, rx_q[base+i], exp_b[i]); end
    end
    exp_cnt[5] = 32'd3; exp_cnt[6] = 32'd10;
    build_exp();
    for (int i = 0; i < 34; i++) begin
      total++;
      if (rx_q[base+34+i] !== exp_b[i])
        begin bad++; $display("FAIL b2b_f2_byte%0d got=%h exp=%h", i, rx_q[base+34+i], exp_b[i]); end
    end
  endtask

  task automatic test_stall();
    int c, extra, changed;
    auto_uart = 1'b0; man_busy = 1'b0;
    do_reset();
    pulse_dump();
    c = 0;
    while (done !== 1'b1 && c < 10) begin step(); c++; end
    total++;
    if (done !== 1'b1 || data_o !== 8'hA5)
      begin bad++; $display("FAIL stall_first got done=%b data=%h exp 1/A5", done, data_o); end
    extra = 0; changed = 0;
    repeat (100) begin
      step();
      if (done !== 1'b0) extra++;
      if (data_o !== 8'hA5) changed++;
    end
    total++;
    if (extra !== 0 || changed !== 0 || busy_o !== 1'b1)
      begin bad++; $display("FAIL stall_hold got extra_done=%0d data_changes=%0d busy=%b exp 0/0/1", extra, changed, busy_o); end
    man_busy = 1'b1; repeat (3) step();
    total++;
    if (done !== 1'b0 || data_o !== 8'hA5)
      begin bad++; $display("FAIL stall_busy got done=%b data=%h exp 0/A5", done, data_o); end
    man_busy = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 10) begin step(); c++; end
    total++;
    if (done !== 1'b1 || data_o !== 8'h00)
      begin bad++; $display("FAIL stall_next got done=%b data=%h exp 1/00", done, data_o); end
    auto_uart = 1'b1;
    do_reset();
  endtask

  initial begin
    rstn = 1'b0; ev_i = '0; clear_i = 1'b0; dump_req = 1'b0;
    auto_uart = 1'b1; man_busy = 1'b0;
    repeat (3) step();
    test_reset();
    test_basic();
    test_saturation();
    test_clear();
    test_back_to_back();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
